ysyx_25030093_lsu_ext: RTL and testbench

YSYX_25030093_LSU_EXT -- requirements
Module: ysyx_25030093_lsu_ext

---
 rtl/ysyx_25030093_lsu_ext.sv | 194 +++++++++++++++++++
 tb/tb_ysyx_25030093_lsu_ext.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030093_lsu_ext.sv
// Load/store unit front end: validates an access, issues one memory request,
// aligns store lanes, extends load data and hands one result downstream.
module ysyx_25030093_lsu_ext #(
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter logic [31:0] MMIO_LIMIT = 32'h1000_0FFF,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ld_data,
  output logic        err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshakes: an access moves on an edge where in_valid && in_ready, a result
  // leaves on an edge where out_valid && out_ready; valid never waits on ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  op_q, op_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        err_q, err_d;
  logic        out_valid_q, out_valid_d;

  logic        illegal;
  logic        is_mmio;
  logic [3:0]  base_mask;
  logic [31:0] lane_data;
  logic [31:0] ld_ext;

  always_comb begin
    illegal = (op[1:0] == 2'b11)
            | ((op[1:0] == 2'b01) & addr[0])
            | ((op[1:0] == 2'b10) & (addr[1:0] != 2'b00))
            | (op[2] & op[3]);
    is_mmio = (addr >= MMIO_BASE) && (addr <= MMIO_LIMIT);
    case (op[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase

    // Move the addressed lane down to bit 0, then extend by access size.
    lane_data = mem_rdata >> {lane_q, 3'b000};
    case (op_q[1:0])
      2'b00:   ld_ext = {{24{~op_q[2] & lane_data[7]}}, lane_data[7:0]};
      2'b01:   ld_ext = {{16{~op_q[2] & lane_data[15]}}, lane_data[15:0]};
      default: ld_ext = lane_data;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    op_d        = op_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_size_d  = mem_size_q;
    mem_wen_d   = mem_wen_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    ld_data_d   = ld_data_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          lane_d = addr[1:0];
          op_d   = op;
          cnt_d  = 16'd0;
          if (illegal) begin
            state_d     = S_DONE;
            err_d       = 1'b1;
            ld_data_d   = 32'd0;
            out_valid_d = 1'b1;
          end else begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_addr_d  = is_mmio ? addr : {addr[31:2], 2'b00};
            mem_size_d  = is_mmio ? op[1:0] : 2'b10;
            mem_wen_d   = op[3];
            mem_wdata_d = st_data << {addr[1:0], 3'b000};
            mem_wmask_d = op[3] ? (base_mask << addr[1:0]) : 4'b0000;
          end
        end
      end
      S_REQ: begin
        // A response on the final counted cycle still wins over the timeout.
        if (mem_resp) begin
          state_d     = S_DONE;
          mem_req_d   = 1'b0;
          err_d       = 1'b0;
          ld_data_d   = op_q[3] ? 32'd0 : ld_ext;
          out_valid_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          mem_req_d   = 1'b0;
          err_d       = 1'b1;
          ld_data_d   = 32'd0;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        mem_req_d   = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      lane_q      <= 2'b00;
      op_q        <= 4'b0000;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_size_q  <= 2'b00;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= 32'd0;
      mem_wmask_q <= 4'b0000;
      ld_data_q   <= 32'd0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      op_q        <= op_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_size_q  <= mem_size_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      ld_data_q   <= ld_data_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign ld_data   = ld_data_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_size  = mem_size_q;
  assign mem_wen   = mem_wen_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ysyx_25030093_lsu_ext.sv
// Bench for ysyx_25030093_lsu_ext: directed vector table, reset/timeout
// sequences and randomized accesses checked against an arithmetic model.
module tb_ysyx_25030093_lsu_ext;

  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ld_data;
  logic        err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  always #5 clock = ~clock;

  ysyx_25030093_lsu_ext #(
    .MMIO_BASE (32'h1000_0000),
    .MMIO_LIMIT(32'h1000_0FFF),
    .TIMEOUT   (TO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .addr     (addr),
    .st_data  (st_data),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ld_data  (ld_data),
    .err      (err),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_size (mem_size),
    .mem_wen  (mem_wen),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_resp (mem_resp),
    .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog no_finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  op;
    logic [31:0] st;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] e_maddr;
    logic [1:0]  e_size;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
    logic [31:0] e_ld;
    logic        e_err;
    int          e_reqc;
  } vec_t;

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [3:0] o, input logic [31:0] st,
                              input logic [31:0] rd, input int dly, input logic [31:0] maddr,
                              input logic [1:0] sz, input logic [3:0] msk, input logic [31:0] wd,
                              input logic [31:0] ld, input logic e, input int reqc);
    vec_t v;
    v.addr = a; v.op = o; v.st = st; v.rdata = rd; v.delay = dly;
    v.e_maddr = maddr; v.e_size = sz; v.e_mask = msk; v.e_wdata = wd;
    v.e_ld = ld; v.e_err = e; v.e_reqc = reqc;
    return v;
  endfunction

  // Reference model: derives the expected outcome from the access rules directly.
  function automatic vec_t model(input logic [31:0] a, input logic [3:0] o, input logic [31:0] st,
                                 input logic [31:0] rd, input int dly);
    vec_t v;
    int sz, nb, off;
    bit store, zext, bad, mmio;
    logic [31:0] val, msk;
    sz    = int'(o[1:0]);
    nb    = 1 << sz;
    off   = int'(a % 32'd4);
    store = o[3];
    zext  = o[2];
    bad   = (sz == 3) || ((a % 32'(nb)) != 0) || (store && zext);
    mmio  = (a >= 32'h1000_0000) && (a <= 32'h1000_0FFF);
    v = mk(a, o, st, rd, dly, 0, 0, 0, 0, 0, 0, 0);
    if (bad) begin
      v.e_err = 1'b1;
      return v;
    end
    v.e_maddr = mmio ? a : a - 32'(off);
    v.e_size  = mmio ? o[1:0] : 2'b10;
    v.e_wdata = st << (8 * off);
    v.e_mask  = store ? 4'(((1 << nb) - 1) << off) : 4'b0000;
    if (dly >= TO) begin
      v.e_err  = 1'b1;
      v.e_reqc = TO;
    end else begin
      v.e_reqc = dly + 1;
      if (!store) begin
        val = rd >> (8 * off);
        if (nb < 4) begin
          msk = (32'd1 << (8 * nb)) - 32'd1;
          val = val & msk;
          if (!zext && val[8 * nb - 1]) val = val | ~msk;
        end
        v.e_ld = val;
      end
    end
    return v;
  endfunction

  // ---------------- driver ----------------
  // Entered and left on a negedge with the DUT idle.
  task automatic run_txn(input vec_t v, input int hold);
    int cyc, reqc;
    exp_q.push_back(v.e_ld);
    exp_err_q.push_back(v.e_err);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; addr = v.addr; op = v.op; st_data = v.st;
    @(negedge clock);
    in_valid = 1'b0; addr = $urandom; op = 4'($urandom); st_data = $urandom;
    cyc = 0; reqc = 0;
    while (!out_valid && cyc < 50) begin
      if (mem_req) begin
        check("mem_addr", mem_addr, v.e_maddr);
        check("mem_size", 32'(mem_size), 32'(v.e_size));
        check("mem_wen", 32'(mem_wen), 32'(v.op[3]));
        check("mem_wdata", mem_wdata, v.e_wdata);
        check("mem_wmask", 32'(mem_wmask), 32'(v.e_mask));
        check("req_in_ready", 32'(in_ready), 32'd0);
        mem_rdata = v.rdata;
        mem_resp  = (reqc == v.delay);
        reqc++;
      end
      @(negedge clock);
      mem_resp = 1'b0; mem_rdata = $urandom;
      cyc++;
    end
    if (!out_valid) begin
      checks++; failures++;
      $display("FAIL txn_wait actual=no_out_valid required=out_valid addr=%h", v.addr);
    end
    check("req_cycles", 32'(reqc), 32'(v.e_reqc));
    check("latency", 32'(cyc), 32'(v.e_reqc));
    check("ld_data", ld_data, exp_q.pop_front());
    check("err", 32'(err), 32'(exp_err_q.pop_front()));
    for (int i = 0; i < hold; i++) begin
      mem_resp = 1'b1; mem_rdata = ~v.rdata;
      @(negedge clock);
      mem_resp = 1'b0;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ld", ld_data, v.e_ld);
      check("hold_err", 32'(err), 32'(v.e_err));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_mem_req", 32'(mem_req), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("exit_valid", 32'(out_valid), 32'd0);
    check("exit_in_ready", 32'(in_ready), 32'd1);
  endtask

  // ---------------- test ----------------
  vec_t tbl[14];
  vec_t rv;
  logic [31:0] ra;

  initial begin
    reset = 1'b1; in_valid = 1'b0; addr = '0; st_data = '0; op = '0;
    out_ready = 1'b0; mem_resp = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wmask", 32'(mem_wmask), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    tbl[0]  = mk(32'h8000_0003, 4'b0000, 32'h0, 32'h80AA_BBCC, 1, 32'h8000_0000, 2'b10, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
    tbl[1]  = mk(32'h8000_0002, 4'b0101, 32'h0, 32'hF00D_1234, 0, 32'h8000_0000, 2'b10, 4'b0000, 32'h0, 32'h0000_F00D, 1'b0, 1);
    tbl[2]  = mk(32'h1000_03F9, 4'b1000, 32'h41, 32'hFFFF_FFFF, 2, 32'h1000_03F9, 2'b00, 4'b0010, 32'h0000_4100, 32'h0, 1'b0, 3);
    tbl[3]  = mk(32'h8000_0002, 4'b0010, 32'h0, 32'h0, 0, 32'h0, 2'b00, 4'b0000, 32'h0, 32'h0, 1'b1, 0);
    tbl[4]  = mk(32'h8000_0000, 4'b0010, 32'h0, 32'h1234_5678, 99, 32'h8000_0000, 2'b10, 4'b0000, 32'h0, 32'h0, 1'b1, 4);
    tbl[5]  = mk(32'h8000_0010, 4'b0010, 32'h0, 32'h1234_5678, 3, 32'h8000_0010, 2'b10, 4'b0000, 32'h0, 32'h1234_5678, 1'b0, 4);
    tbl[6]  = mk(32'h1000_0FFE, 4'b0001, 32'h0, 32'h8001_5555, 0, 32'h1000_0FFE, 2'b01, 4'b0000, 32'h0, 32'hFFFF_8001, 1'b0, 1);
    tbl[7]  = mk(32'h1000_1000, 4'b1010, 32'hDEAD_BEEF, 32'h0, 1, 32'h1000_1000, 2'b10, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    tbl[8]  = mk(32'h0FFF_FFFF, 4'b0100, 32'h0, 32'hAB00_0000, 0, 32'h0FFF_FFFC, 2'b10, 4'b0000, 32'h0, 32'h0000_00AB, 1'b0, 1);
    tbl[9]  = mk(32'h8000_0000, 4'b0011, 32'h0, 32'h0, 0, 32'h0, 2'b00, 4'b0000, 32'h0, 32'h0, 1'b1, 0);
    tbl[10] = mk(32'h8000_0000, 4'b1100, 32'h0, 32'h0, 0, 32'h0, 2'b00, 4'b0000, 32'h0, 32'h0, 1'b1, 0);
    tbl[11] = mk(32'h1000_0001, 4'b1001, 32'h0, 32'h0, 0, 32'h0, 2'b00, 4'b0000, 32'h0, 32'h0, 1'b1, 0);
    tbl[12] = mk(32'h1000_0002, 4'b1001, 32'h0000_BEEF, 32'h0, 0, 32'h1000_0002, 2'b01, 4'b1100, 32'hBEEF_0000, 32'h0, 1'b0, 1);
    tbl[13] = mk(32'h1000_0000, 4'b0000, 32'h0, 32'h1234_567F, 0, 32'h1000_0000, 2'b00, 4'b0000, 32'h0, 32'h0000_007F, 1'b0, 1);

    for (int i = 0; i < 14; i++) run_txn(tbl[i], (i < 3) ? 3 : i % 3);

    // Timeout, then a stray response while idle must change nothing.
    run_txn(tbl[4], 0);
    mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clock);
    mem_resp = 1'b0;
    check("idle_resp_valid", 32'(out_valid), 32'd0);
    check("idle_resp_req", 32'(mem_req), 32'd0);
    check("idle_resp_in_ready", 32'(in_ready), 32'd1);
    check("idle_resp_ld", ld_data, 32'd0);

    // Reset while a request is outstanding, with a response in the reset cycle.
    in_valid = 1'b1; addr = 32'h8000_0020; op = 4'b0010; st_data = 32'h0;
    @(negedge clock);
    in_valid = 1'b0;
    check("pre_rst_req", 32'(mem_req), 32'd1);
    @(negedge clock);
    reset = 1'b1; mem_resp = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clock);
    reset = 1'b0; mem_resp = 1'b0;
    check("rst_req_mem_req", 32'(mem_req), 32'd0);
    check("rst_req_in_ready", 32'(in_ready), 32'd1);
    check("rst_req_valid", 32'(out_valid), 32'd0);
    check("rst_req_ld", ld_data, 32'd0);
    @(negedge clock);
    check("rst_req_after_valid", 32'(out_valid), 32'd0);
    run_txn(tbl[0], 1);

    // Randomized accesses against the model.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'h8000_0000 + 32'($urandom_range(0, 255));
        1:       ra = 32'h1000_0000 + 32'($urandom_range(0, 4095));
        2:       ra = 32'h1000_0FFC + 32'($urandom_range(0, 7));
        default: ra = 32'h0FFF_FFFC + 32'($urandom_range(0, 7));
      endcase
      rv = model(ra, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 5));
      run_txn(rv, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
